pipelined_vector_adder: RTL and testbench

PIPELINED_VECTOR_ADDER -- requirements
Module: pipelined_vector_adder

---
 rtl/pipelined_vector_adder_if.sv | 28 ++
 rtl/pipelined_vector_adder.sv | 106 ++++++++++
 tb/tb_pipelined_vector_adder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_vector_adder_if.sv
// Operand/result stream bundle for pipelined_vector_adder.
// The producer/consumer side uses master; the adder uses slave.
interface pipelined_vector_adder_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LANES = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*WIDTH-1:0]   a;
   logic [LANES*WIDTH-1:0]   b;
   logic                     sub;
   logic                     sat;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*WIDTH-1:0]   sum;
   logic [LANES-1:0]         cout;
   logic [LANES-1:0]         ovf;

   modport master (
      output in_valid, a, b, sub, sat, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, sat, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_vector_adder.sv
// Multi-lane add/subtract with optional signed saturation.
// Each lane ripples its carry through SEGS pipeline stages of SW bits each.
module pipelined_vector_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LANES = 4,
   parameter int unsigned SEGS  = 4
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_vector_adder_if.slave bus
);
   localparam int unsigned SW = WIDTH / SEGS;
   localparam int unsigned W  = LANES * WIDTH;

   logic adv;

   // Stage registers; index k holds the beat after segment k has been added.
   logic             vld_q [SEGS];
   logic             sat_q [SEGS];
   logic [W-1:0]     a_q   [SEGS];
   logic [W-1:0]     b_q   [SEGS];
   logic [W-1:0]     res_q [SEGS];
   logic [LANES-1:0] cy_q  [SEGS];
   logic [LANES-1:0] ovf_q [SEGS];

   // Stage inputs: the accepted beat for stage 0, the previous register otherwise.
   logic             vld_i [SEGS];
   logic             sat_i [SEGS];
   logic [W-1:0]     a_i   [SEGS];
   logic [W-1:0]     b_i   [SEGS];
   logic [W-1:0]     res_i [SEGS];
   logic [LANES-1:0] cy_i  [SEGS];

   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < SEGS; k++) begin : g_stage
      logic [W-1:0]     res_d;
      logic [LANES-1:0] cy_d;
      logic [LANES-1:0] ovf_d;

      if (k == 0) begin : g_head
         // B is inverted and sub seeds the carry, so subtraction needs no later flag.
         assign vld_i[k] = bus.in_valid;
         assign sat_i[k] = bus.sat;
         assign a_i[k]   = bus.a;
         assign b_i[k]   = bus.b ^ {W{bus.sub}};
         assign res_i[k] = '0;
         assign cy_i[k]  = {LANES{bus.sub}};
      end else begin : g_body
         assign vld_i[k] = vld_q[k-1];
         assign sat_i[k] = sat_q[k-1];
         assign a_i[k]   = a_q[k-1];
         assign b_i[k]   = b_q[k-1];
         assign res_i[k] = res_q[k-1];
         assign cy_i[k]  = cy_q[k-1];
      end

      always_comb begin
         logic [SW:0] seg;
         seg   = '0;
         res_d = res_i[k];
         cy_d  = '0;
         ovf_d = '0;
         for (int l = 0; l < LANES; l++) begin
            seg = {1'b0, a_i[k][l*WIDTH + k*SW +: SW]}
                + {1'b0, b_i[k][l*WIDTH + k*SW +: SW]}
                + (SW+1)'(cy_i[k][l]);
            res_d[l*WIDTH + k*SW +: SW] = seg[SW-1:0];
            cy_d[l] = seg[SW];
            // Carry into the segment MSB recovered as a ^ b ^ sum at that bit.
            ovf_d[l] = a_i[k][l*WIDTH + k*SW + SW - 1] ^ b_i[k][l*WIDTH + k*SW + SW - 1]
                     ^ seg[SW-1] ^ seg[SW];
            if (k == SEGS - 1 && sat_i[k] && ovf_d[l]) begin
               res_d[l*WIDTH +: WIDTH] = seg[SW-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                   : {1'b1, {(WIDTH-1){1'b0}}};
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q[k] <= 1'b0;
            sat_q[k] <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            res_q[k] <= '0;
            cy_q[k]  <= '0;
            ovf_q[k] <= '0;
         end else if (adv) begin
            vld_q[k] <= vld_i[k];
            sat_q[k] <= sat_i[k];
            a_q[k]   <= a_i[k];
            b_q[k]   <= b_i[k];
            res_q[k] <= res_d;
            cy_q[k]  <= cy_d;
            ovf_q[k] <= ovf_d;
         end
      end
   end

   assign bus.out_valid = vld_q[SEGS-1];
   assign bus.sum       = res_q[SEGS-1];
   assign bus.cout      = cy_q[SEGS-1];
   assign bus.ovf       = ovf_q[SEGS-1];
endmodule

// File: tb/tb_pipelined_vector_adder.sv
// Bench for pipelined_vector_adder (WIDTH=8, LANES=2, SEGS=2): directed beats,
// backpressure, mid-flight reset and a random stream against a signed-arithmetic model.
module tb_pipelined_vector_adder;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned LANES = 2;
   localparam int unsigned SEGS  = 2;
   localparam int unsigned W     = LANES * WIDTH;

   typedef struct packed {
      logic [W-1:0]     sum;
      logic [LANES-1:0] cout;
      logic [LANES-1:0] ovf;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   delivered = 0;
   beat_t exp_q[$];

   pipelined_vector_adder_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   pipelined_vector_adder #(.WIDTH(WIDTH), .LANES(LANES), .SEGS(SEGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic per lane.
   function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic sat);
      beat_t r;
      logic [WIDTH-1:0] al, bl;
      int unsigned ua, ub, ur;
      int sa, sb, sr;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         al = a[l*WIDTH +: WIDTH];
         bl = b[l*WIDTH +: WIDTH];
         ua = al;
         ub = bl;
         ur = sub ? ua + 256 - ub : ua + ub;
         sa = $signed(al);
         sb = $signed(bl);
         sr = sub ? sa - sb : sa + sb;
         r.cout[l] = (ur >= 256);
         r.ovf[l]  = (sr > 127) || (sr < -128);
         if (sat && r.ovf[l]) r.sum[l*WIDTH +: WIDTH] = (sr > 0) ? 8'h7F : 8'h80;
         else                 r.sum[l*WIDTH +: WIDTH] = 8'(ur);
      end
      return r;
   endfunction

   // Scoreboard: checks every output cycle, handshake rule and stall stability.
   logic        stall_prev = 1'b0;
   logic [31:0] held;
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
         if (stall_prev)
            chk("stall_stable", {11'b0, bus.out_valid, bus.ovf, bus.cout, bus.sum}, held);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
               e = exp_q[0];
               chk("sum",  32'(bus.sum),  32'(e.sum));
               chk("cout", 32'(bus.cout), 32'(e.cout));
               chk("ovf",  32'(bus.ovf),  32'(e.ovf));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  delivered++;
               end
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held = {11'b0, bus.out_valid, bus.ovf, bus.cout, bus.sum};
         if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.sat));
      end
   end

   // Offer one beat and hold it until accepted; returns the acceptance cycle.
   task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic t, output int acc);
      bus.a = a; bus.b = b; bus.sub = s; bus.sat = t; bus.in_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (acc < 0) chk("push_timeout", 32'd1, 32'd0);
      else begin @(posedge clk); #1; end
   endtask

   task automatic wait_out(input int acc, output beat_t r, output int lat);
      bit found = 1'b0;
      r = '0;
      lat = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            r = {bus.sum, bus.cout, bus.ovf};
            lat = cyc - acc;
            found = 1'b1;
            break;
         end
      end
      if (!found) chk("out_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
   endtask

   typedef struct packed {
      logic [W-1:0] a, b;
      logic sub, sat;
      logic [W-1:0] sum;
      logic [LANES-1:0] cout, ovf;
   } vec_t;

   vec_t vecs [3] = '{
      '{16'h7F0F, 16'h0101, 1'b0, 1'b0, 16'h8010, 2'b00, 2'b10},
      '{16'h7F0F, 16'h0101, 1'b0, 1'b1, 16'h7F10, 2'b00, 2'b10},
      '{16'h8000, 16'h0101, 1'b1, 1'b1, 16'h80FF, 2'b10, 2'b10}
   };

   initial begin
      int acc, lat, base, seen;
      beat_t r;
      bit done;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.sat = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum",       32'(bus.sum),       32'd0);
      chk("rst_cout",      32'(bus.cout),      32'd0);
      chk("rst_ovf",       32'(bus.ovf),       32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;

      // Directed beats with hand-computed results.
      for (int i = 0; i < 3; i++) begin
         push_beat(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, acc);
         bus.in_valid = 1'b0;
         wait_out(acc, r, lat);
         chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(SEGS));
         chk($sformatf("dir%0d_sum", i),  32'(r.sum),  32'(vecs[i].sum));
         chk($sformatf("dir%0d_cout", i), 32'(r.cout), 32'(vecs[i].cout));
         chk($sformatf("dir%0d_ovf", i),  32'(r.ovf),  32'(vecs[i].ovf));
      end

      // Backpressure: 3-cycle consumer stall in the middle of a 4-beat stream.
      base = delivered;
      fork
         begin
            push_beat(16'h0102, 16'h0304, 1'b0, 1'b0, acc);
            push_beat(16'h40C0, 16'h40C0, 1'b0, 1'b1, acc);
            push_beat(16'h10FF, 16'h2001, 1'b1, 1'b0, acc);
            push_beat(16'h8001, 16'h7F02, 1'b1, 1'b1, acc);
            bus.in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               if (bus.out_valid) break;
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_delivered", 32'(delivered - base), 32'd4);

      // Reset with two beats inside the pipe.
      bus.out_ready = 1'b0;
      push_beat(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
      push_beat(16'h3333, 16'h4444, 1'b0, 1'b0, acc);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_sum",       32'(bus.sum),       32'd0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("midrst_no_emit", 32'(seen), 32'd0);
      @(posedge clk); #1;

      // Random stream with random consumer readiness and input bubbles.
      base = delivered;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               push_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
               if ($urandom_range(0, 7) == 0) begin
                  bus.in_valid = 1'b0;
                  @(posedge clk); #1;
               end
            end
            bus.in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();
      chk("rand_delivered", 32'(delivered - base), 32'd1000);
      chk("queue_empty",    32'(exp_q.size()),     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
